fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_arbiter_if.sv | 30 +++
 rtl/fb_wr_fifo.sv | 38 +++
 rtl/fb_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, parameter defaults and arbiter state encoding
package fb_pkg;
  localparam int GB_W = 160;
  localparam int GB_H = 144;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 2;
  localparam int FB_DEPTH_DEF = GB_W * GB_H;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;
endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: bus bundle between framebuffer clients, arbiter and RAM
// rd_*: scanout read strobe/address and returned pixel
// wr_*: capture-side valid/ready write handshake
// ram_*: single-port synchronous RAM, one-cycle read latency
// modports: slave = arbiter side, master = client/RAM side
interface fb_arbiter_if import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output rd_valid, rd_data, wr_ready, ram_addr, ram_we, ram_wdata
  );
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  rd_valid, rd_data, wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous write buffer with registered occupancy count
// clk/reset: clock, synchronous active-high reset
// push/din: enqueue; pop/dout: dequeue, dout shows the head entry
// full/empty: decoded from the registered count
module fb_wr_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: framebuffer RAM arbiter for scanout reads, buffered capture writes and frame clear
// clk/reset: single clock, synchronous active-high reset
// bus (slave): rd_req/rd_addr -> rd_valid/rd_data two cycles later; wr_valid/wr_ready/wr_addr/wr_data
//   capture writes; ram_addr/ram_we/ram_wdata/ram_rdata single-port sync RAM
// clr_start/clr_busy: frame-clear request pulse, high while draining or clearing
// addr_err: sticky flag for discarded out-of-range writes
// stall_count: saturating count of wr_valid && !wr_ready cycles, only with FB_ARB_STATS_EN defined
module fb_arbiter import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int FB_DEPTH = FB_DEPTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fb_arbiter_if.slave bus,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        addr_err,
  output logic [15:0] stall_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
  fb_state_t state;
  logic [ADDR_W-1:0] clr_addr, head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W+DATA_W-1:0] head;
  logic full, empty, push, pop, clr_we, rd_p1;
  fb_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset, .push, .pop,
    .din({bus.wr_addr, bus.wr_data}), .dout(head), .full, .empty
  );
  assign {head_addr, head_data} = head;
  assign clr_busy = state != IDLE;
  assign bus.wr_ready = !reset && !full && state == IDLE;
  assign push = bus.wr_valid && bus.wr_ready;
  // reads always win; the FIFO drains only outside CLEAR, the clear counter only inside it
  assign pop = !reset && !bus.rd_req && state != CLEAR && !empty;
  assign clr_we = !reset && !bus.rd_req && state == CLEAR;
  always_comb begin
    bus.ram_addr = bus.rd_req ? bus.rd_addr : clr_we ? clr_addr : pop ? head_addr : bus.rd_addr;
    bus.ram_we = clr_we || (pop && head_addr <= LAST);
    bus.ram_wdata = clr_we ? '0 : head_data;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      clr_addr <= '0;
      addr_err <= 1'b0;
      rd_p1 <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      rd_p1 <= bus.rd_req;
      bus.rd_valid <= rd_p1;
      if (rd_p1) bus.rd_data <= bus.ram_rdata;
      if (pop && head_addr > LAST) addr_err <= 1'b1;
      if (state == IDLE && clr_start) state <= DRAIN;
      else if (state == DRAIN && empty) begin
        state <= CLEAR;
        clr_addr <= '0;
      end else if (clr_we) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST) state <= IDLE;
      end
    end
`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (bus.wr_valid && !bus.wr_ready && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
`else
  assign stall_count = '0;
`endif
endmodule
